// File: rtl/forward_select_unit.sv
// forward_select_unit: EX operand-mux select codes and load-use stall from a shadow dest-tag pipeline.
// Optional FWD_STATS_EN macro enables saturating stall/forward counters; otherwise those ports read 0.
module forward_select_unit #(
  parameter int NB_REG_ADDR = 5,
  parameter int NB_SEL      = 2
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   enable_i,
  input  logic                   flush_i,
  input  logic                   id_valid_i,
  input  logic [NB_REG_ADDR-1:0] id_rs_i,
  input  logic [NB_REG_ADDR-1:0] id_rt_i,
  input  logic                   id_uses_rt_i,
  input  logic [NB_REG_ADDR-1:0] id_rd_i,
  input  logic                   id_reg_write_i,
  input  logic                   id_mem_to_reg_i,
  output logic [NB_SEL-1:0]      fwd_a_sel_o,
  output logic [NB_SEL-1:0]      fwd_b_sel_o,
  output logic                   stall_o,
  output logic [15:0]            stall_count_o,
  output logic [15:0]            fwd_count_o
);
  typedef struct packed {
    logic                   v;
    logic                   w;
    logic                   ld;
    logic [NB_REG_ADDR-1:0] rd;
  } ent_t;
  ent_t              pipe_q [4];
  ent_t              pipe_d [4];
  logic [NB_SEL-1:0] a_q, a_d, b_q, b_d;
  logic              issue;
  function automatic logic hit(input ent_t e, input logic [NB_REG_ADDR-1:0] src);
    return e.v & e.w & (e.rd != '0) & (e.rd == src);
  endfunction
  // Entries are examined as seen from ID; each moves one stage before the consumer reaches EX.
  function automatic logic [NB_SEL-1:0] sel(input ent_t ex, input ent_t mem, input ent_t wb,
                                            input logic [NB_REG_ADDR-1:0] src);
    return hit(ex, src) ? 2'b01 : hit(mem, src) ? 2'b10 : hit(wb, src) ? 2'b11 : 2'b00;
  endfunction
  always_comb begin
    stall_o   = ~reset_i & id_valid_i & pipe_q[0].v & pipe_q[0].ld & (pipe_q[0].rd != '0) &
                ((pipe_q[0].rd == id_rs_i) | (id_uses_rt_i & (pipe_q[0].rd == id_rt_i)));
    issue     = id_valid_i & ~stall_o & ~flush_i;
    pipe_d[0] = '{v: issue, w: id_reg_write_i, ld: id_mem_to_reg_i, rd: id_rd_i};
    pipe_d[1] = pipe_q[0];
    pipe_d[2] = pipe_q[1];
    pipe_d[3] = pipe_q[2];
    a_d       = issue ? sel(pipe_q[0], pipe_q[1], pipe_q[2], id_rs_i) : '0;
    b_d       = (issue & id_uses_rt_i) ? sel(pipe_q[0], pipe_q[1], pipe_q[2], id_rt_i) : '0;
  end
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      pipe_q <= '{default: '0};
      a_q    <= '0;
      b_q    <= '0;
    end else if (enable_i) begin
      pipe_q <= pipe_d;
      a_q    <= a_d;
      b_q    <= b_d;
    end
  end
  assign fwd_a_sel_o = a_q;
  assign fwd_b_sel_o = b_q;
`ifdef FWD_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d, fwd_cnt_q, fwd_cnt_d;
  always_comb begin
    stall_cnt_d = stall_cnt_q + 16'(stall_o & ~&stall_cnt_q);
    fwd_cnt_d   = fwd_cnt_q + 16'(((|a_d) | (|b_d)) & ~&fwd_cnt_q);
  end
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else if (enable_i) begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end
  assign stall_count_o = stall_cnt_q;
  assign fwd_count_o   = fwd_cnt_q;
`else
  assign stall_count_o = '0;
  assign fwd_count_o   = '0;
`endif
endmodule

// File: tb/tb_forward_select_unit.sv
// tb_forward_select_unit: directed instruction stream with a queue of expected EX selects.
module tb_forward_select_unit;
  logic        clk = 1'b0;
  logic        reset_i = 1'b1, enable_i = 1'b0, flush_i = 1'b0;
  logic        id_valid_i = 1'b0, id_uses_rt_i = 1'b0, id_reg_write_i = 1'b0, id_mem_to_reg_i = 1'b0;
  logic [4:0]  id_rs_i = '0, id_rt_i = '0, id_rd_i = '0;
  logic [1:0]  fwd_a_sel_o, fwd_b_sel_o;
  logic        stall_o;
  logic [15:0] stall_count_o, fwd_count_o;
  int          checks = 0, errors = 0;
  typedef struct {
    string      tag;
    logic [1:0] a;
    logic [1:0] b;
  } exp_t;
  exp_t sb[$];

  forward_select_unit dut (
    .clock_i(clk), .reset_i(reset_i), .enable_i(enable_i), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_uses_rt_i(id_uses_rt_i),
    .id_rd_i(id_rd_i), .id_reg_write_i(id_reg_write_i), .id_mem_to_reg_i(id_mem_to_reg_i),
    .fwd_a_sel_o(fwd_a_sel_o), .fwd_b_sel_o(fwd_b_sel_o), .stall_o(stall_o),
    .stall_count_o(stall_count_o), .fwd_count_o(fwd_count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic ut,
                       input logic [4:0] rd, input logic rw, input logic ld, input logic fl);
    id_valid_i = v; id_rs_i = rs; id_rt_i = rt; id_uses_rt_i = ut;
    id_rd_i = rd; id_reg_write_i = rw; id_mem_to_reg_i = ld; flush_i = fl;
  endtask

  task automatic step(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic ut,
                      input logic [4:0] rd, input logic rw, input logic ld, input logic fl,
                      input logic [1:0] ea, input logic [1:0] eb, input logic es, input string tag);
    exp_t e;
    @(negedge clk);
    enable_i = 1'b1;
    drive(v, rs, rt, ut, rd, rw, ld, fl);
    #1 chk({tag, ".stall"}, 16'(stall_o), 16'(es));
    sb.push_back('{tag, ea, eb});
    @(posedge clk);
    #1 e = sb.pop_front();
    chk({e.tag, ".a"}, 16'(fwd_a_sel_o), 16'(e.a));
    chk({e.tag, ".b"}, 16'(fwd_b_sel_o), 16'(e.b));
  endtask

  task automatic alu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [1:0] ea, input logic [1:0] eb, input logic es, input string tag);
    step(1, rs, rt, 1, rd, 1, 0, 0, ea, eb, es, tag);
  endtask

  task automatic lw(input logic [4:0] rd, input logic [4:0] rs, input string tag);
    step(1, rs, rd, 0, rd, 1, 1, 0, 2'b00, 2'b00, 1'b0, tag);
  endtask

  task automatic nop();
    step(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1'b0, "nop");
  endtask

  task automatic chk_counts(input string tag, input logic [15:0] es, input logic [15:0] ef);
`ifdef FWD_STATS_EN
    chk({tag, ".stall_cnt"}, stall_count_o, es);
    chk({tag, ".fwd_cnt"}, fwd_count_o, ef);
`else
    chk({tag, ".stall_cnt"}, stall_count_o, 16'h0);
    chk({tag, ".fwd_cnt"}, fwd_count_o, 16'h0);
`endif
  endtask

  initial begin
    drive(1, 5'd1, 5'd1, 1, 5'd9, 1, 0, 0);
    repeat (2) @(posedge clk);
    #1 chk("rst.a", 16'(fwd_a_sel_o), 16'h0);
    chk("rst.b", 16'(fwd_b_sel_o), 16'h0);
    chk("rst.stall", 16'(stall_o), 16'h0);
    chk_counts("rst", 0, 0);
    @(negedge clk) reset_i = 1'b0;
    alu(3, 1, 2, 2'b00, 2'b00, 0, "add3_noprod");
    alu(5, 1, 2, 2'b00, 2'b00, 0, "add5");
    alu(6, 5, 5, 2'b01, 2'b01, 0, "sub6_b2b");
    repeat (3) nop();
    alu(5, 1, 2, 2'b00, 2'b00, 0, "add5_g1");
    nop();
    alu(7, 5, 0, 2'b10, 2'b00, 0, "or7_gap1");
    repeat (3) nop();
    alu(5, 1, 2, 2'b00, 2'b00, 0, "add5_g2");
    repeat (2) nop();
    alu(7, 5, 0, 2'b11, 2'b00, 0, "or7_gap2");
    repeat (3) nop();
    alu(5, 1, 2, 2'b00, 2'b00, 0, "add5_g3");
    repeat (3) nop();
    alu(7, 5, 0, 2'b00, 2'b00, 0, "or7_gap3");
    lw(8, 1, "lw8");
    alu(9, 8, 1, 2'b00, 2'b00, 1, "add9_stall");
    alu(9, 8, 1, 2'b10, 2'b00, 0, "add9_after");
    chk_counts("loaduse", 1, 4);
    lw(10, 1, "lw10");
    step(1, 2, 10, 0, 11, 1, 0, 0, 2'b00, 2'b00, 0, "addi_rt_unused");
    alu(0, 1, 2, 2'b00, 2'b00, 0, "wr0_a");
    alu(0, 1, 2, 2'b00, 2'b00, 0, "wr0_b");
    alu(3, 0, 0, 2'b00, 2'b00, 0, "rd0");
    lw(0, 1, "lw0");
    alu(3, 0, 0, 2'b00, 2'b00, 0, "rd0_after_lw0");
    alu(4, 1, 2, 2'b00, 2'b00, 0, "add4_a");
    alu(4, 1, 2, 2'b00, 2'b00, 0, "add4_b");
    alu(3, 4, 4, 2'b01, 2'b01, 0, "nearest");
    step(1, 1, 2, 1, 12, 1, 0, 1, 2'b00, 2'b00, 0, "add12_flush");
    alu(13, 12, 12, 2'b00, 2'b00, 0, "after_flush");
    lw(14, 1, "lw14");
    step(1, 14, 1, 1, 15, 1, 0, 1, 2'b00, 2'b00, 1, "flush_stall");
    alu(15, 14, 1, 2'b10, 2'b00, 0, "after_flush_stall");
    chk_counts("pre_rst", 2, 6);
    lw(16, 1, "lw16");
    @(negedge clk);
    drive(1, 16, 1, 1, 17, 1, 0, 0);
    #1 chk("mid.stall_pre", 16'(stall_o), 16'h1);
    reset_i = 1'b1;
    #1 chk("mid.stall_in_rst", 16'(stall_o), 16'h0);
    @(posedge clk);
    #1 chk("mid.a", 16'(fwd_a_sel_o), 16'h0);
    chk("mid.b", 16'(fwd_b_sel_o), 16'h0);
    chk_counts("mid", 0, 0);
    @(negedge clk) reset_i = 1'b0;
    #1 chk("mid.stall_post", 16'(stall_o), 16'h0);
    alu(17, 16, 1, 2'b00, 2'b00, 0, "add17_post_rst");
    alu(18, 1, 2, 2'b00, 2'b00, 0, "add18");
    alu(19, 18, 1, 2'b01, 2'b00, 0, "add19");
    @(negedge clk);
    enable_i = 1'b0;
    drive(1, 19, 19, 1, 20, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 chk("hold.a", 16'(fwd_a_sel_o), 16'h1);
      chk("hold.b", 16'(fwd_b_sel_o), 16'h0);
    end
    chk_counts("hold", 0, 1);
    alu(20, 19, 19, 2'b01, 2'b01, 0, "add20_resume");
    lw(21, 1, "lw21");
    @(negedge clk);
    enable_i = 1'b0;
    drive(1, 21, 1, 1, 22, 1, 0, 0);
    #1 chk("hold_stall.pre", 16'(stall_o), 16'h1);
    @(posedge clk);
    #1 chk("hold_stall.stall", 16'(stall_o), 16'h1);
    chk("hold_stall.a", 16'(fwd_a_sel_o), 16'h0);
    alu(22, 21, 1, 2'b00, 2'b00, 1, "add22_stall");
    alu(22, 21, 1, 2'b10, 2'b00, 0, "add22_after");
    chk_counts("final", 1, 3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
